// File: rtl/sa_pkg.sv
// Shared constants and encodings for the systolic-array drain path.
// Imported by the drain collector and its output stream interface.
package sa_pkg;

  localparam int ROW_NUM         = 16;
  localparam int COLUMN_NUM      = 16;
  localparam int PIXEL_WIDTH_18  = 16;
  localparam int SA_OUT_WIDTH    = PIXEL_WIDTH_18 * 4 * COLUMN_NUM;
  localparam int GROUP_CNT_WIDTH = 8;
  localparam int ROW_IDX_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef enum logic {
    MODE_88 = 1'b0,
    MODE_18 = 1'b1
  } sa_mode_t;

  // A zero group count would otherwise drain forever; treat it as one group.
  function automatic logic [GROUP_CNT_WIDTH-1:0] eff_groups(
    input logic [GROUP_CNT_WIDTH-1:0] n
  );
    return (n == '0) ? GROUP_CNT_WIDTH'(1) : n;
  endfunction

endpackage

// File: rtl/sa_drain_collector_if.sv
// Valid/ready row stream from the drain collector to the output-buffer writer.
// The master drives the row and its tags; the slave returns out_ready.
interface sa_drain_collector_if
  import sa_pkg::*;
#(
  parameter int DATA_W = SA_OUT_WIDTH,
  parameter int GRP_W  = GROUP_CNT_WIDTH
) ();

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [ROW_IDX_WIDTH-1:0] out_row_idx;
  logic [GRP_W-1:0]         out_group_idx;
  logic                     out_mode;
  logic                     out_last;

  modport master (
    output out_valid, out_data, out_row_idx, out_group_idx, out_mode, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row_idx, out_group_idx, out_mode, out_last,
    output out_ready
  );

endinterface

// File: rtl/sa_drain_collector.sv
// Drains SA result rows group by group into a one-deep output register,
// pausing sa_channel_out_en whenever the downstream stalls a held row.
module sa_drain_collector #(
  parameter int ROW_NUM         = sa_pkg::ROW_NUM,
  parameter int COLUMN_NUM      = sa_pkg::COLUMN_NUM,
  parameter int PIXEL_WIDTH_18  = sa_pkg::PIXEL_WIDTH_18,
  parameter int SA_OUT_WIDTH    = PIXEL_WIDTH_18 * 4 * COLUMN_NUM,
  parameter int GROUP_CNT_WIDTH = sa_pkg::GROUP_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic [GROUP_CNT_WIDTH-1:0] n_groups,
  output logic                       sa_channel_out_reset,
  output logic                       sa_channel_out_en,
  input  logic [SA_OUT_WIDTH-1:0]    sa_out,
  sa_drain_collector_if.master       out_if,
  output logic                       busy,
  output logic                       done
);
  import sa_pkg::*;

  state_t                     state_reg, state_next;
  logic [ROW_IDX_WIDTH-1:0]   row_cnt_reg;
  logic [GROUP_CNT_WIDTH-1:0] grp_cnt_reg;
  logic [GROUP_CNT_WIDTH-1:0] n_grp_reg;
  logic                       mode_reg;
  logic                       out_valid_reg;
  logic                       out_last_reg;
  logic [SA_OUT_WIDTH-1:0]    out_data_reg;
  logic [ROW_IDX_WIDTH-1:0]   out_row_idx_reg;
  logic [GROUP_CNT_WIDTH-1:0] out_group_idx_reg;

  logic take;
  logic row_wrap;
  logic final_row;
  logic accept;

  assign row_wrap  = (row_cnt_reg == ROW_IDX_WIDTH'(ROW_NUM - 1));
  assign final_row = row_wrap && (grp_cnt_reg == n_grp_reg - GROUP_CNT_WIDTH'(1));
  assign accept    = out_valid_reg && out_if.out_ready;

  always_comb begin
    state_next           = state_reg;
    take                 = 1'b0;
    sa_channel_out_reset = 1'b0;
    sa_channel_out_en    = 1'b0;
    done                 = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        sa_channel_out_reset = 1'b1;
        state_next           = DRAIN;
      end
      DRAIN: begin
        // The SA row counter advances with en, so en must mirror take exactly.
        take              = !out_valid_reg || out_if.out_ready;
        sa_channel_out_en = take;
        if (take && final_row) state_next = FLUSH;
      end
      FLUSH: begin
        if (accept) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      row_cnt_reg       <= '0;
      grp_cnt_reg       <= '0;
      n_grp_reg         <= '0;
      mode_reg          <= 1'b0;
      out_valid_reg     <= 1'b0;
      out_last_reg      <= 1'b0;
      out_data_reg      <= '0;
      out_row_idx_reg   <= '0;
      out_group_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        mode_reg    <= mode;
        n_grp_reg   <= eff_groups(n_groups);
        row_cnt_reg <= '0;
        grp_cnt_reg <= '0;
      end
      if (take) begin
        out_data_reg      <= sa_out;
        out_row_idx_reg   <= row_cnt_reg;
        out_group_idx_reg <= grp_cnt_reg;
        out_valid_reg     <= 1'b1;
        out_last_reg      <= final_row;
        row_cnt_reg       <= row_wrap ? '0 : row_cnt_reg + ROW_IDX_WIDTH'(1);
        if (row_wrap) grp_cnt_reg <= grp_cnt_reg + GROUP_CNT_WIDTH'(1);
      end
      if (state_reg == FLUSH && accept) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  assign out_if.out_valid     = out_valid_reg;
  assign out_if.out_data      = out_data_reg;
  assign out_if.out_row_idx   = out_row_idx_reg;
  assign out_if.out_group_idx = out_group_idx_reg;
  assign out_if.out_mode      = mode_reg;
  assign out_if.out_last      = out_last_reg;
  assign busy                 = (state_reg != IDLE);

endmodule

// File: tb/tb_sa_drain_collector.sv
// Directed bench for sa_drain_collector with a counting SA model whose rows
// encode {4'hA, group, row}; beats and control events are logged at negedge.
module tb_sa_drain_collector;
  import sa_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       start = 1'b0;
  logic                       mode = 1'b0;
  logic [GROUP_CNT_WIDTH-1:0] n_groups = '0;
  logic                       chan_rst, chan_en, busy, done;
  logic [SA_OUT_WIDTH-1:0]    sa_out;

  sa_drain_collector_if ob ();

  sa_drain_collector dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .mode                 (mode),
    .n_groups             (n_groups),
    .sa_channel_out_reset (chan_rst),
    .sa_channel_out_en    (chan_en),
    .sa_out               (sa_out),
    .out_if               (ob),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SA model: not tied to reset_n, only recovered by the collector's CLEAR.
  logic [3:0] sa_cnt = 4'd0;
  logic [7:0] sa_grp = 8'd0;
  always @(posedge clk) begin
    if (chan_rst) begin
      sa_cnt <= 4'd0;
      sa_grp <= 8'd0;
    end else if (chan_en) begin
      sa_cnt <= sa_cnt + 4'd1;
      if (sa_cnt == 4'd15) sa_grp <= sa_grp + 8'd1;
    end
  end
  assign sa_out = {(SA_OUT_WIDTH/16){{4'hA, sa_grp, sa_cnt}}};

  function automatic logic [SA_OUT_WIDTH-1:0] exp_row(input int g, input int r);
    logic [15:0] w;
    w = {4'hA, 8'(g), 4'(r)};
    return {(SA_OUT_WIDTH/16){w}};
  endfunction

  logic [SA_OUT_WIDTH-1:0] b_data[$];
  logic [3:0]              b_row[$];
  logic [7:0]              b_grp[$];
  bit                      b_last[$];
  bit                      b_mode[$];
  int                      clr_rel[$];
  int                      en_rel[$];
  int                      d_rel[$];
  int                      viol = 0;

  always @(negedge clk) begin
    if (ob.out_valid && ob.out_ready) begin
      b_data.push_back(ob.out_data);
      b_row.push_back(ob.out_row_idx);
      b_grp.push_back(ob.out_group_idx);
      b_last.push_back(ob.out_last);
      b_mode.push_back(ob.out_mode);
    end
    if (chan_rst) clr_rel.push_back(cyc - t0);
    if (chan_en) en_rel.push_back(cyc - t0);
    if (done) d_rel.push_back(cyc - t0);
    if (chan_en && ob.out_valid && !ob.out_ready) viol <= viol + 1;
  end

  // Launches one job; out_ready follows 1,0,0,1 when bp is set.
  // At cycle inj_at a second start is pulsed with a different mode/n_groups.
  task automatic run_job(input logic [7:0] ng, input logic md, input bit bp,
                         input int inj_at, output bit timed_out);
    int k;
    int dbase;
    dbase = d_rel.size();
    @(posedge clk); #1;
    start = 1'b1; mode = md; n_groups = ng; t0 = cyc; ob.out_ready = 1'b1;
    k = 0;
    timed_out = 1'b0;
    while (d_rel.size() == dbase) begin
      @(posedge clk); #1;
      k++;
      start = (k == inj_at);
      if (k == inj_at) begin
        mode = ~md;
        n_groups = 8'd2;
      end
      ob.out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (k > 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
    ob.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ob.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (ob.out_valid !== 1'b0 || ob.out_last !== 1'b0 || ob.out_mode !== 1'b0 ||
        ob.out_row_idx !== 4'd0 || ob.out_group_idx !== 8'd0 || ob.out_data !== '0) begin
      errs++;
      $display("FAIL reset_stream: valid %0b last %0b mode %0b row %0d grp %0d, want all 0",
               ob.out_valid, ob.out_last, ob.out_mode, ob.out_row_idx, ob.out_group_idx);
    end
    vec++;
    if ({busy, done, chan_rst, chan_en} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_ctrl: busy/done/rst/en %b, want 0000", {busy, done, chan_rst, chan_en});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: busy %0b, want 0", busy);
    end
  endtask

  task automatic test_basic();
    int bb, cb, eb, nb;
    bit to;
    bb = b_row.size(); cb = clr_rel.size(); eb = en_rel.size();
    run_job(8'd1, MODE_18, 1'b0, -1, to);
    nb = b_row.size() - bb;
    vec++;
    if (to) begin errs++; $display("FAIL basic_timeout: done not seen, want done"); end
    vec++;
    if (clr_rel.size() - cb != 1 || clr_rel[cb] != 1) begin
      errs++;
      $display("FAIL basic_clear: %0d pulses first at %0d, want 1 at 1", clr_rel.size() - cb, clr_rel[cb]);
    end
    vec++;
    if (en_rel.size() - eb != 16 || en_rel[eb] != 2 || en_rel[eb + 15] != 17) begin
      errs++;
      $display("FAIL basic_en: %0d cycles %0d..%0d, want 16 cycles 2..17",
               en_rel.size() - eb, en_rel[eb], en_rel[eb + 15]);
    end
    vec++;
    if (nb != 16) begin errs++; $display("FAIL basic_beats: %0d, want 16", nb); end
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (b_row[bb + i] !== 4'(i) || b_grp[bb + i] !== 8'd0 || b_data[bb + i] !== exp_row(0, i) ||
          b_last[bb + i] !== (i == 15) || b_mode[bb + i] !== 1'b1) begin
        errs++;
        $display("FAIL basic_beat%0d: row %0d grp %0d last %0b mode %0b data %h, want row %0d grp 0 last %0b mode 1 data %h",
                 i, b_row[bb + i], b_grp[bb + i], b_last[bb + i], b_mode[bb + i],
                 b_data[bb + i][15:0], i, (i == 15), exp_row(0, i)[15:0]);
      end
    end
    vec++;
    if (d_rel[d_rel.size() - 1] != 18) begin
      errs++;
      $display("FAIL basic_done: at %0d, want 18", d_rel[d_rel.size() - 1]);
    end
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || ob.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_idle: busy %0b valid %0b, want 0 0", busy, ob.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int bb, eb, nb, vb;
    bit to;
    bb = b_row.size(); eb = en_rel.size(); vb = viol;
    run_job(8'd1, MODE_88, 1'b1, -1, to);
    nb = b_row.size() - bb;
    vec++;
    if (to) begin errs++; $display("FAIL bp_timeout: done not seen, want done"); end
    vec++;
    if (viol != vb) begin errs++; $display("FAIL bp_stall_en: %0d en-while-stalled, want 0", viol - vb); end
    vec++;
    if (nb != 16 || en_rel.size() - eb != 16) begin
      errs++;
      $display("FAIL bp_counts: beats %0d en %0d, want 16 16", nb, en_rel.size() - eb);
    end
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (b_row[bb + i] !== 4'(i) || b_data[bb + i] !== exp_row(0, i) ||
          b_last[bb + i] !== (i == 15) || b_mode[bb + i] !== 1'b0) begin
        errs++;
        $display("FAIL bp_beat%0d: row %0d last %0b mode %0b data %h, want row %0d last %0b mode 0 data %h",
                 i, b_row[bb + i], b_last[bb + i], b_mode[bb + i], b_data[bb + i][15:0],
                 i, (i == 15), exp_row(0, i)[15:0]);
      end
    end
    vec++;
    if (sa_cnt !== 4'd0) begin errs++; $display("FAIL bp_sa_cnt: %0d, want 0", sa_cnt); end
  endtask

  task automatic test_multi_group();
    int bb, cb, nb;
    bit to;
    bb = b_row.size(); cb = clr_rel.size();
    run_job(8'd3, MODE_18, 1'b0, -1, to);
    nb = b_row.size() - bb;
    vec++;
    if (to) begin errs++; $display("FAIL multi_timeout: done not seen, want done"); end
    vec++;
    if (nb != 48 || clr_rel.size() - cb != 1) begin
      errs++;
      $display("FAIL multi_counts: beats %0d clears %0d, want 48 1", nb, clr_rel.size() - cb);
    end
    for (int i = 0; i < 48; i++) begin
      vec++;
      if (b_row[bb + i] !== 4'(i % 16) || b_grp[bb + i] !== 8'(i / 16) ||
          b_data[bb + i] !== exp_row(i / 16, i % 16) || b_last[bb + i] !== (i == 47)) begin
        errs++;
        $display("FAIL multi_beat%0d: row %0d grp %0d last %0b data %h, want row %0d grp %0d last %0b data %h",
                 i, b_row[bb + i], b_grp[bb + i], b_last[bb + i], b_data[bb + i][15:0],
                 i % 16, i / 16, (i == 47), exp_row(i / 16, i % 16)[15:0]);
      end
    end
    vec++;
    if (d_rel[d_rel.size() - 1] != 50) begin
      errs++;
      $display("FAIL multi_done: at %0d, want 50", d_rel[d_rel.size() - 1]);
    end
  endtask

  task automatic test_zero_groups();
    int bb, nb;
    bit to;
    bb = b_row.size();
    run_job(8'd0, MODE_18, 1'b0, -1, to);
    nb = b_row.size() - bb;
    vec++;
    if (to) begin errs++; $display("FAIL zero_timeout: done not seen, want done"); end
    vec++;
    if (nb != 16 || b_last[bb + 15] !== 1'b1 || b_grp[bb + 15] !== 8'd0) begin
      errs++;
      $display("FAIL zero_beats: beats %0d last15 %0b grp15 %0d, want 16 1 0",
               nb, b_last[bb + 15], b_grp[bb + 15]);
    end
    vec++;
    if (d_rel[d_rel.size() - 1] != 18) begin
      errs++;
      $display("FAIL zero_done: at %0d, want 18", d_rel[d_rel.size() - 1]);
    end
  endtask

  task automatic test_mid_reset();
    int bb, cb, k, nb;
    bit to;
    bb = b_row.size();
    @(posedge clk); #1;
    start = 1'b1; mode = MODE_18; n_groups = 8'd1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (b_row.size() - bb < 7 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    vec++;
    if (busy !== 1'b1 || ob.out_valid !== 1'b1) begin
      errs++;
      $display("FAIL midrst_pre: busy %0b valid %0b, want 1 1", busy, ob.out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    vec++;
    if (ob.out_valid !== 1'b0 || ob.out_data !== '0 || ob.out_row_idx !== 4'd0 ||
        ob.out_mode !== 1'b0 || ob.out_last !== 1'b0 || busy !== 1'b0 || chan_en !== 1'b0) begin
      errs++;
      $display("FAIL midrst_async: valid %0b row %0d mode %0b last %0b busy %0b en %0b, want all 0",
               ob.out_valid, ob.out_row_idx, ob.out_mode, ob.out_last, busy, chan_en);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bb = b_row.size(); cb = clr_rel.size();
    run_job(8'd1, MODE_88, 1'b0, -1, to);
    nb = b_row.size() - bb;
    vec++;
    if (to || nb != 16 || clr_rel.size() - cb != 1) begin
      errs++;
      $display("FAIL midrst_rerun: timeout %0b beats %0d clears %0d, want 0 16 1", to, nb, clr_rel.size() - cb);
    end
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (b_row[bb + i] !== 4'(i) || b_data[bb + i] !== exp_row(0, i) || b_mode[bb + i] !== 1'b0) begin
        errs++;
        $display("FAIL midrst_beat%0d: row %0d mode %0b data %h, want row %0d mode 0 data %h",
                 i, b_row[bb + i], b_mode[bb + i], b_data[bb + i][15:0], i, exp_row(0, i)[15:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int bb, cb, nb, badmode;
    bit to;
    bb = b_row.size(); cb = clr_rel.size();
    run_job(8'd1, MODE_18, 1'b0, 5, to);
    nb = b_row.size() - bb;
    badmode = 0;
    for (int i = 0; i < nb; i++) if (b_mode[bb + i] !== 1'b1) badmode++;
    vec++;
    if (to) begin errs++; $display("FAIL busy_timeout: done not seen, want done"); end
    vec++;
    if (clr_rel.size() - cb != 1) begin
      errs++;
      $display("FAIL busy_clears: %0d, want 1", clr_rel.size() - cb);
    end
    vec++;
    if (nb != 16 || b_last[bb + 15] !== 1'b1) begin
      errs++;
      $display("FAIL busy_beats: %0d last15 %0b, want 16 1", nb, b_last[bb + 15]);
    end
    vec++;
    if (badmode != 0) begin errs++; $display("FAIL busy_mode: %0d beats with mode!=1, want 0", badmode); end
    vec++;
    if (d_rel[d_rel.size() - 1] != 18) begin
      errs++;
      $display("FAIL busy_done: at %0d, want 18", d_rel[d_rel.size() - 1]);
    end
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0) begin errs++; $display("FAIL busy_after: busy %0b, want 0", busy); end
  endtask

  initial begin
    ob.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_multi_group();
    test_zero_groups();
    test_mid_reset();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/sa_drain_collector.md
Name: sa_drain_collector

Overview:
- Drives the systolic array's channel-out drain protocol from the consuming side: `sa_channel_out_reset` and `sa_channel_out_en`.
- Captures one SA result row per enabled cycle into an output register and presents the rows to the output-buffer writer over a valid/ready stream.
- Sits between the SA and the output/requant path.
- Deasserts `sa_channel_out_en` to apply backpressure, so no SA row is ever lost or duplicated.

Parameters:
- ROW_NUM, 16, SA rows; also the rows per drain group.
- COLUMN_NUM, 16, SA columns.
- PIXEL_WIDTH_18, 16, per-pixel accumulator width in mode 1.
- SA_OUT_WIDTH, PIXEL_WIDTH_18*4*COLUMN_NUM (1024), width of one SA output row.
- GROUP_CNT_WIDTH, 8, width of the drain-group count.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a drain job; honoured only in IDLE.
- mode  in  1  SA mode (0 = 8x8, 1 = 1x8); sampled at start.
- n_groups  in  GROUP_CNT_WIDTH  number of 16-row groups to drain; 0 is treated as 1.
- sa_channel_out_reset  out  1  clears the SA row counter.
- sa_channel_out_en  out  1  SA drain enable; the SA row counter advances on every cycle this is high.
- sa_out  in  SA_OUT_WIDTH  SA output row; valid in the same cycle as sa_channel_out_en.
- out_valid  out  1  out_data holds a captured row.
- out_ready  in  1  downstream accepts the row.
- out_data  out  SA_OUT_WIDTH  captured row.
- out_row_idx  out  4  SA row index of out_data (0..15).
- out_group_idx  out  GROUP_CNT_WIDTH  group index of out_data.
- out_mode  out  1  mode latched at start.
- out_last  out  1  last row of the last group.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the final row is accepted.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE; every output and internal register = 0, including out_data and the counters.
- States: IDLE, CLEAR, DRAIN, FLUSH.
- IDLE:
  - start=1 → latch mode into out_mode; latch n_groups (0 becomes 1); zero row_cnt and grp_cnt; go to CLEAR.
  - start in any other state is ignored.
- CLEAR: sa_channel_out_reset=1 for exactly one cycle, sa_channel_out_en=0; next state DRAIN.
- DRAIN:
  - take = !out_valid || out_ready; sa_channel_out_en = take (combinational from registered state and out_ready).
  - On take:
    - out_data ← sa_out, out_row_idx ← row_cnt, out_group_idx ← grp_cnt, out_valid ← 1.
    - out_last ← (row_cnt == 15 && grp_cnt == n_groups−1).
    - row_cnt wraps 15 → 0; grp_cnt increments on that wrap.
  - On the final row's take, go to FLUSH.
  - No CLEAR is issued between groups: the SA counter self-wraps at 15, and row_cnt mirrors it exactly.
- FLUSH:
  - sa_channel_out_en=0.
  - When out_valid && out_ready: out_valid←0, out_last←0, done=1 for one cycle, state←IDLE.
- Stream rule: out_valid=1 and !out_ready → out_data, out_row_idx, out_group_idx and out_last hold, and sa_channel_out_en=0.
- Stream rule: out_valid && out_ready in DRAIN → simultaneous accept and reload; out_valid stays 1.
- Throughput and latency:
  - 1 row/cycle with out_ready held high.
  - First sa_channel_out_en occurs 2 cycles after start (CLEAR, then DRAIN).
  - done asserts 16·n_groups + 2 cycles after start at minimum.
- Width: sa_out is passed through unmodified. In mode 0 the upper SA_OUT_WIDTH − 768 bits are zero by SA contract; out_mode tags the row for the unpacker.
- mode and n_groups changing after start have no effect until the next job.
- Reset mid-drain aborts the job; the SA counter is recovered by the next job's CLEAR.

Decomposition:
- Shared package sa_pkg holds:
  - state encoding: IDLE=0, CLEAR=1, DRAIN=2, FLUSH=3;
  - ROW_NUM / COLUMN_NUM / SA_OUT_WIDTH constants;
  - the mode encoding (MODE_88=0, MODE_18=1).
- A single module; no sub-module. The output register plus the take logic is too small to split out.

Test Plan:
- Basic drain: n_groups=1, mode=1, out_ready=1, SA model with row r = {64{r[15:0]}}.
  - sa_channel_out_reset at cycle 1.
  - en high cycles 2–17.
  - 16 beats with row_idx 0..15 and correct data.
  - out_last on beat 15.
  - done at cycle 18.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly.
  - en never high while out_valid && !out_ready.
  - All 16 rows delivered exactly once, in order.
  - SA model counter equals 0 at end.
- Multi-group: n_groups=3.
  - 48 beats; group_idx 0,1,2.
  - Only one CLEAR pulse.
  - out_last only on group 2, row 15.
- n_groups=0 → behaves as 1: 16 beats, then done.
- Mid-drain reset: assert reset_n=0 after 7 rows.
  - All outputs go to 0 immediately, state IDLE.
  - Next start re-CLEARs and delivers rows 0..15 correctly.
- Start ignored while busy, and mode change during the job:
  - no second CLEAR;
  - out_mode keeps its start value;
  - beat count is unchanged.
